// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. Fixed data-over-fetch priority with a starvation guard that
// forces a fetch grant after STARVE_LIMIT consecutive data grants. One
// transaction in flight; optional response timeout reports an error.
// Optional feature: define ARB_PERF_CNT_EN to add the per-requester stall
// counters if_stall_cnt / d_stall_cnt.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,   // 1..15
  parameter int TIMEOUT      = 16   // 0 disables, 1..255
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       d_stall_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state, state_nxt;
  owner_t              owner;
  logic [3:0]          starve_cnt;
  logic [7:0]          tmo_cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                force_if;
  logic                tmo_hit;
  logic                done;

  // Fetch wins only once data has been granted STARVE_LIMIT times in a row.
  assign force_if = if_req && (starve_cnt == STARVE_MAX);
  assign tmo_hit  = (TIMEOUT != 0) && (state == WAIT) && !m_ack && (tmo_cnt == TMO_LAST);
  // A same-cycle m_ack beats the timeout: either way the transaction ends.
  assign done     = (state == WAIT) && (m_ack || tmo_hit);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Arbitration and next state; grants only exist in IDLE.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        d_gnt  = d_req & ~force_if;
        if_gnt = if_req & (~d_req | force_if);
        if (d_gnt || if_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request and its owner; run the timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_cnt <= '0;
    end else if (d_gnt) begin
      owner   <= OWN_D;
      we_q    <= d_we;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      tmo_cnt <= '0;
    end else if (if_gnt) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= if_addr;
      wdata_q <= '0;
      tmo_cnt <= '0;
    end else if (state == WAIT && !m_ack) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Count consecutive data grants that left a pending fetch waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 starve_cnt <= '0;
    else if (!if_req || if_gnt)   starve_cnt <= '0;
    else if (d_gnt && starve_cnt != STARVE_MAX)
                                  starve_cnt <= starve_cnt + 4'd1;
  end

  // Response pulse to the owner; data/err hold between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= done && (owner == OWN_IF);
      d_rvalid  <= done && (owner == OWN_D);
      if (done && owner == OWN_IF) begin
        if_rdata <= m_ack ? m_rdata : '0;
        if_err   <= ~m_ack;
      end
      if (done && owner == OWN_D) begin
        d_rdata  <= (m_ack && !we_q) ? m_rdata : '0;
        d_err    <= ~m_ack;
      end
    end
  end

  assign m_req   = (state == WAIT);
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
  // Saturating stall counters: cycles with a request pending but not granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_stall_cnt <= '0;
      d_stall_cnt  <= '0;
    end else begin
      if (if_req && !if_gnt && if_stall_cnt != 32'hFFFF_FFFF)
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (d_req && !d_gnt && d_stall_cnt != 32'hFFFF_FFFF)
        d_stall_cnt <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenario tasks plus a response
// scoreboard that pairs each rvalid pulse with the expected rdata/err.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 0, d_req = 0, d_we = 0, m_ack = 0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
  logic        m_req, m_we, busy;
  logic [63:0] if_rdata, d_rdata, m_addr, m_wdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt, d_stall_cnt;
`endif

  typedef struct { logic [63:0] data; logic err; } rsp_t;
  rsp_t if_q[$];
  rsp_t d_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
  );

  task automatic tick; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk);     endtask

  // Scoreboard: every rvalid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (if_rvalid) begin
      n_cmp++;
      if (if_q.size() == 0) begin
        n_err++; $display("FAIL if_rsp: unexpected if_rvalid, expected none");
      end else begin
        rsp_t e;
        e = if_q.pop_front();
        if (if_rdata !== e.data || if_err !== e.err) begin
          n_err++;
          $display("FAIL if_rsp: rdata=%h err=%b expected rdata=%h err=%b", if_rdata, if_err, e.data, e.err);
        end
      end
    end
    if (d_rvalid) begin
      n_cmp++;
      if (d_q.size() == 0) begin
        n_err++; $display("FAIL d_rsp: unexpected d_rvalid, expected none");
      end else begin
        rsp_t e;
        e = d_q.pop_front();
        if (d_rdata !== e.data || d_err !== e.err) begin
          n_err++;
          $display("FAIL d_rsp: rdata=%h err=%b expected rdata=%h err=%b", d_rdata, d_err, e.data, e.err);
        end
      end
    end
  end

  task automatic test_reset;
    smp;
    n_cmp++;
    if ({if_gnt, d_gnt, m_req, busy, if_rvalid, d_rvalid, if_err, d_err, m_we} !== 9'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b expected 0", {if_gnt, d_gnt, m_req, busy, if_rvalid, d_rvalid, if_err, d_err, m_we});
    end
    n_cmp++;
    if (if_rdata !== 64'h0 || d_rdata !== 64'h0 || m_addr !== 64'h0 || m_wdata !== 64'h0) begin
      n_err++; $display("FAIL reset_data: if_rdata=%h d_rdata=%h m_addr=%h m_wdata=%h expected 0", if_rdata, d_rdata, m_addr, m_wdata);
    end
    tick; reset_n = 1'b1;
  endtask

  task automatic test_single_fetch;
    tick; if_req = 1; if_addr = 64'h100;
    smp;
    n_cmp++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      n_err++; $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b expected 1 0", if_gnt, d_gnt);
    end
    tick; if_req = 0;
    smp;
    n_cmp++;
    if (m_req !== 1'b1 || m_addr !== 64'h100 || m_we !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL fetch_mreq: m_req=%b m_addr=%h m_we=%b busy=%b expected 1 100 0 1", m_req, m_addr, m_we, busy);
    end
    m_ack = 1; m_rdata = 64'h00500093;
    if_q.push_back('{64'h00500093, 1'b0});
    tick; m_ack = 0; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    smp;
    n_cmp++;
    if (if_rvalid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL fetch_rvalid: if_rvalid=%b busy=%b expected 1 0", if_rvalid, busy);
    end
    tick;
    smp;
    n_cmp++;
    if (if_rvalid !== 1'b0 || if_rdata !== 64'h00500093) begin
      n_err++; $display("FAIL fetch_pulse: if_rvalid=%b if_rdata=%h expected 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_collision;
    tick; if_req = 1; if_addr = 64'h300;
    d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'hDEAD;
    smp;
    n_cmp++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_err++; $display("FAIL coll_gnt: d_gnt=%b if_gnt=%b expected 1 0", d_gnt, if_gnt);
    end
    tick; d_req = 0; d_we = 0;
    smp;
    n_cmp++;
    if (m_we !== 1'b1 || m_addr !== 64'h200 || m_wdata !== 64'hDEAD || if_gnt !== 1'b0) begin
      n_err++; $display("FAIL coll_mem: m_we=%b m_addr=%h m_wdata=%h if_gnt=%b expected 1 200 dead 0", m_we, m_addr, m_wdata, if_gnt);
    end
    m_ack = 1; m_rdata = 64'h1234_5678;
    d_q.push_back('{64'h0, 1'b0});
    tick; m_ack = 0;
    smp;
    n_cmp++;
    if (d_rvalid !== 1'b1 || if_gnt !== 1'b1) begin
      n_err++; $display("FAIL coll_follow: d_rvalid=%b if_gnt=%b expected 1 1", d_rvalid, if_gnt);
    end
    tick; if_req = 0;
    smp;
    n_cmp++;
    if (m_addr !== 64'h300 || m_we !== 1'b0 || m_wdata !== 64'h0) begin
      n_err++; $display("FAIL coll_fetch: m_addr=%h m_we=%b m_wdata=%h expected 300 0 0", m_addr, m_we, m_wdata);
    end
    m_ack = 1; m_rdata = 64'hABC;
    if_q.push_back('{64'hABC, 1'b0});
    tick; m_ack = 0;
    smp;
  endtask

  task automatic test_starvation;
    byte last;
    byte g;
    byte exp_g;
    int  ngr;
    logic [63:0] r;
    last = "-"; ngr = 0;
    tick; if_req = 1; if_addr = 64'h500; d_req = 1; d_we = 0; d_addr = 64'h600;
    for (int guard = 0; guard < 100 && ngr < 10; guard++) begin
      smp;
      if (!busy) begin
        g = d_gnt ? "D" : (if_gnt ? "I" : "-");
        exp_g = (ngr % 5 == 4) ? "I" : "D";
        n_cmp++;
        if (g !== exp_g || (if_gnt && d_gnt)) begin
          n_err++; $display("FAIL starve_seq[%0d]: grant=%s expected %s", ngr, g, exp_g);
        end
        last = g; ngr++;
      end else begin
        r = {$urandom, $urandom};
        m_ack = 1; m_rdata = r;
        if (last == "I") if_q.push_back('{r, 1'b0});
        else             d_q.push_back('{r, 1'b0});
      end
      tick; m_ack = 0;
    end
    n_cmp++;
    if (ngr != 10) begin
      n_err++; $display("FAIL starve_count: grants=%0d expected 10", ngr);
    end
    if_req = 0; d_req = 0;
    smp;
    r = {$urandom, $urandom};
    m_ack = 1; m_rdata = r;
    if (last == "I") if_q.push_back('{r, 1'b0});
    else             d_q.push_back('{r, 1'b0});
    tick; m_ack = 0;
    smp;
  endtask

  task automatic test_timeout;
    int cnt;
    bit ended;
    cnt = 0; ended = 0;
    tick; d_req = 1; d_we = 0; d_addr = 64'h400;
    smp;
    n_cmp++;
    if (d_gnt !== 1'b1) begin
      n_err++; $display("FAIL tmo_gnt: d_gnt=%b expected 1", d_gnt);
    end
    d_q.push_back('{64'h0, 1'b1});
    tick; d_req = 0;
    for (int i = 0; i < 40 && !ended; i++) begin
      smp;
      if (!m_req) ended = 1;
      else begin cnt++; tick; end
    end
    n_cmp++;
    if (cnt != 16 || !ended) begin
      n_err++; $display("FAIL tmo_len: m_req cycles=%0d expected 16", cnt);
    end
    n_cmp++;
    if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 64'h0) begin
      n_err++; $display("FAIL tmo_rsp: d_rvalid=%b d_err=%b d_rdata=%h expected 1 1 0", d_rvalid, d_err, d_rdata);
    end
  endtask

  task automatic test_stray_ack;
    tick; m_ack = 1; m_rdata = 64'h5555;
    smp;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL stray_busy: busy=%b expected 0", busy);
    end
    tick; m_ack = 0;
    smp;
    n_cmp++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL stray_rvalid: if_rvalid=%b d_rvalid=%b expected 0 0", if_rvalid, d_rvalid);
    end
  endtask

  task automatic test_reset_mid;
    tick; if_req = 1; if_addr = 64'h700;
    smp;
    tick; if_req = 0;
    smp;
    n_cmp++;
    if (m_req !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: m_req=%b expected 1", m_req);
    end
    #1 reset_n = 0;
    #1;
    n_cmp++;
    if (m_req !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: m_req=%b busy=%b expected 0 0", m_req, busy);
    end
    tick; tick; reset_n = 1;
    smp;
    tick;
    smp;
    n_cmp++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_norsp: if_rvalid=%b d_rvalid=%b expected 0 0", if_rvalid, d_rvalid);
    end
    tick; if_req = 1; if_addr = 64'h800;
    smp;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++; $display("FAIL rstmid_gnt: if_gnt=%b expected 1", if_gnt);
    end
    tick; if_req = 0;
    smp;
    n_cmp++;
    if (m_addr !== 64'h800 || m_req !== 1'b1) begin
      n_err++; $display("FAIL rstmid_addr: m_addr=%h m_req=%b expected 800 1", m_addr, m_req);
    end
    m_ack = 1; m_rdata = 64'hFEED_F00D;
    if_q.push_back('{64'hFEED_F00D, 1'b0});
    tick; m_ack = 0;
    smp;
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_cnt;
    tick; reset_n = 0;
    tick; reset_n = 1;
    tick; d_req = 1; d_we = 1; d_addr = 64'h900; d_wdata = 64'h55;
    smp;
    tick; d_req = 0; d_we = 0; if_req = 1; if_addr = 64'hA00;
    for (int k = 0; k < 5; k++) begin
      smp;
      if (k == 4) begin
        m_ack = 1; m_rdata = 64'h77;
        d_q.push_back('{64'h0, 1'b0});
      end
      tick;
    end
    m_ack = 0;
    smp;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++; $display("FAIL perf_gnt: if_gnt=%b expected 1", if_gnt);
    end
    tick; if_req = 0;
    smp;
    n_cmp++;
    if (if_stall_cnt !== 32'd5 || d_stall_cnt !== 32'd0) begin
      n_err++; $display("FAIL perf_cnt: if_stall=%0d d_stall=%0d expected 5 0", if_stall_cnt, d_stall_cnt);
    end
    m_ack = 1; m_rdata = 64'h99;
    if_q.push_back('{64'h99, 1'b0});
    tick; m_ack = 0;
    smp;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_fetch;
    test_collision;
    test_starvation;
    test_timeout;
    test_stray_ack;
    test_reset_mid;
`ifdef ARB_PERF_CNT_EN
    test_perf_cnt;
`endif
    tick; smp;
    n_cmp++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: if_q=%0d d_q=%0d expected 0 0", if_q.size(), d_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
